// File: rtl/cpu_pkg.sv
// Shared constants for the microcoded CPU sequencer: control-word bit map,
// opcode values, sequencer states and the load-strobe mask.
package cpu_pkg;

  localparam int CTRL_W        = 15;
  localparam int MAX_INSTR_LEN = 5;

  localparam int B_PC_OUT   = 14;
  localparam int B_PC_LOAD  = 13;
  localparam int B_PC_INC   = 12;
  localparam int B_MAR_IN   = 11;
  localparam int B_RAM_OUT  = 10;
  localparam int B_RAM_IN   = 9;
  localparam int B_IR_IN    = 8;
  localparam int B_IR_OUT   = 7;
  localparam int B_A_IN     = 6;
  localparam int B_A_OUT    = 5;
  localparam int B_ALU_OUT  = 4;
  localparam int B_ALU_SUB  = 3;
  localparam int B_B_IN     = 2;
  localparam int B_OUT_IN   = 1;
  localparam int B_FLAGS_IN = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} seq_state_t;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
    return CTRL_W'(1) << idx;
  endfunction

  // Strobes that change register state; masked whenever the step does not advance.
  localparam logic [CTRL_W-1:0] LOAD_MASK =
    ctrl_bit(B_PC_LOAD) | ctrl_bit(B_PC_INC) | ctrl_bit(B_MAR_IN) | ctrl_bit(B_RAM_IN) |
    ctrl_bit(B_IR_IN) | ctrl_bit(B_A_IN) | ctrl_bit(B_B_IN) | ctrl_bit(B_OUT_IN) |
    ctrl_bit(B_FLAGS_IN);

  localparam logic [CTRL_W-1:0] CW_ADDR = ctrl_bit(B_IR_OUT) | ctrl_bit(B_MAR_IN);

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-to-datapath signal bundle; master is the sequencer side.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int MAX_T    = 6
);
  localparam int TW = $clog2(MAX_T);

  logic [OPCODE_W-1:0] opcode;
  logic                flag_c;
  logic                flag_z;
  logic                mem_ready;
  logic                step_mode;
  logic                step;
  logic                resume;
  logic [CTRL_W-1:0]   ctrl;
  logic [TW-1:0]       t_state;
  logic                fetch;
  logic                instr_done;
  logic                halted;

  modport master (
    input  opcode, flag_c, flag_z, mem_ready, step_mode, step, resume,
    output ctrl, t_state, fetch, instr_done, halted
  );

  modport slave (
    output opcode, flag_c, flag_z, mem_ready, step_mode, step, resume,
    input  ctrl, t_state, fetch, instr_done, halted
  );
endinterface

// File: rtl/cpu_ucode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> raw control word,
// last-step marker and halt marker.
module cpu_ucode_rom
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int TW       = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [TW-1:0]       t_state,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [CTRL_W-1:0]   ctrl_raw,
  output logic                last_step,
  output logic                is_halt
);
  logic [3:0] op;
  logic       t2, t3, t4;

  // Any set bit above the 4-bit opcode field makes the instruction a NOP.
  assign op = ((opcode >> 4) != '0) ? OP_NOP : opcode[3:0];
  assign t2 = (t_state == TW'(2));
  assign t3 = (t_state == TW'(3));
  assign t4 = (t_state == TW'(4));

  always_comb begin
    ctrl_raw  = '0;
    last_step = 1'b0;
    is_halt   = 1'b0;
    if (t_state == TW'(0)) begin
      ctrl_raw = ctrl_bit(B_PC_OUT) | ctrl_bit(B_MAR_IN);
    end else if (t_state == TW'(1)) begin
      ctrl_raw = ctrl_bit(B_RAM_OUT) | ctrl_bit(B_IR_IN) | ctrl_bit(B_PC_INC);
    end else begin
      case (op)
        OP_LDA: begin
          if (t2) ctrl_raw = CW_ADDR;
          else if (t3) begin
            ctrl_raw  = ctrl_bit(B_RAM_OUT) | ctrl_bit(B_A_IN);
            last_step = 1'b1;
          end
        end
        OP_ADD, OP_SUB: begin
          if (t2) ctrl_raw = CW_ADDR;
          else if (t3) ctrl_raw = ctrl_bit(B_RAM_OUT) | ctrl_bit(B_B_IN);
          else if (t4) begin
            ctrl_raw = ctrl_bit(B_ALU_OUT) | ctrl_bit(B_A_IN) | ctrl_bit(B_FLAGS_IN);
            if (op == OP_SUB) ctrl_raw[B_ALU_SUB] = 1'b1;
            last_step = 1'b1;
          end
        end
        OP_STA: begin
          if (t2) ctrl_raw = CW_ADDR;
          else if (t3) begin
            ctrl_raw  = ctrl_bit(B_A_OUT) | ctrl_bit(B_RAM_IN);
            last_step = 1'b1;
          end
        end
        OP_LDI: begin
          ctrl_raw  = ctrl_bit(B_IR_OUT) | ctrl_bit(B_A_IN);
          last_step = t2;
        end
        OP_JMP: begin
          ctrl_raw  = ctrl_bit(B_IR_OUT) | ctrl_bit(B_PC_LOAD);
          last_step = t2;
        end
        OP_JC, OP_JZ: begin
          if ((op == OP_JC) ? flag_c : flag_z)
            ctrl_raw = ctrl_bit(B_IR_OUT) | ctrl_bit(B_PC_LOAD);
          last_step = t2;
        end
        OP_OUT: begin
          ctrl_raw  = ctrl_bit(B_A_OUT) | ctrl_bit(B_OUT_IN);
          last_step = t2;
        end
        OP_HLT: begin
          last_step = t2;
          is_halt   = t2;
        end
        default: last_step = t2;
      endcase
    end
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Microcoded T-state sequencer: counter, halt state, RAM-stall and
// single-step gating, and masking of load strobes on non-advancing cycles.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int MAX_T        = 6,
  parameter int STALL_ON_RAM = 1,
  parameter int STEP_EN      = 1
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);
  localparam int TW = $clog2(MAX_T);

  if (MAX_T < MAX_INSTR_LEN || MAX_T > 8) begin : g_bad_max_t
    $error("cpu_sequencer: MAX_T=%0d cannot hold a %0d-step instruction or exceeds 8",
           MAX_T, MAX_INSTR_LEN);
  end

  seq_state_t        state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic              step_mode_q;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              last_step, is_halt;
  logic              stall, idle, adv;

  cpu_ucode_rom #(.OPCODE_W(OPCODE_W), .TW(TW)) u_rom (
    .opcode   (bus.opcode),
    .t_state  (t_q),
    .flag_c   (bus.flag_c),
    .flag_z   (bus.flag_z),
    .ctrl_raw (ctrl_raw),
    .last_step(last_step),
    .is_halt  (is_halt)
  );

  assign stall = (STALL_ON_RAM != 0) && (ctrl_raw[B_RAM_OUT] || ctrl_raw[B_RAM_IN]) &&
                 !bus.mem_ready;
  assign idle  = step_mode_q && !bus.step;
  assign adv   = (state_q == ST_RUN) && !stall && !idle;

  // step_mode is registered so a change only gates from the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      t_q         <= '0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      step_mode_q <= (STEP_EN != 0) && bus.step_mode;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_RUN: begin
        if (adv) begin
          if (last_step) begin
            t_d = '0;
            if (is_halt) state_d = ST_HALT;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      ST_HALT: if (bus.resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    bus.ctrl       = '0;
    bus.instr_done = 1'b0;
    bus.t_state    = t_q;
    bus.halted     = (state_q == ST_HALT);
    bus.fetch      = (state_q == ST_RUN) && (t_q < TW'(2));
    if (!rst && state_q == ST_RUN) begin
      bus.ctrl       = adv ? ctrl_raw : (ctrl_raw & ~LOAD_MASK);
      bus.instr_done = adv && last_step;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: fetch/execute sequences, RAM stall, halt/resume,
// single-step gating and asynchronous reset, all with hand-computed control words.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.OPCODE_W(6), .MAX_T(6)) bus ();

  cpu_sequencer #(
    .OPCODE_W(6), .MAX_T(6), .STALL_ON_RAM(1), .STEP_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [2:0]  sm_t    [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic [14:0] sm_full [4] = '{15'h1500, 15'h0880, 15'h0440, 15'h4800};
  logic [14:0] sm_idle [4] = '{15'h0400, 15'h0080, 15'h0400, 15'h4000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [14:0] c, input logic [2:0] t,
                            input logic d);
    chk({tag, "_ctrl"}, 32'(bus.ctrl), 32'(c));
    chk({tag, "_t"}, 32'(bus.t_state), 32'(t));
    chk({tag, "_done"}, 32'(bus.instr_done), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'h02;
    bus.flag_c    = 1'b0;
    bus.flag_z    = 1'b0;
    bus.mem_ready = 1'b1;
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
    bus.resume    = 1'b0;

    // Reset state
    tick(); #1;
    expect_cyc("reset", 15'h0000, 3'd0, 1'b0);
    chk("reset_fetch", 32'(bus.fetch), 32'd1);
    chk("reset_halted", 32'(bus.halted), 32'd0);

    // ADD: five steps, done only in the last
    tick(); rst = 1'b0; #1;
    expect_cyc("add_t0", 15'h4800, 3'd0, 1'b0);
    chk("add_t0_fetch", 32'(bus.fetch), 32'd1);
    tick(); #1; expect_cyc("add_t1", 15'h1500, 3'd1, 1'b0);
    tick(); #1; expect_cyc("add_t2", 15'h0880, 3'd2, 1'b0);
    chk("add_t2_fetch", 32'(bus.fetch), 32'd0);
    tick(); #1; expect_cyc("add_t3", 15'h0404, 3'd3, 1'b0);
    tick(); #1; expect_cyc("add_t4", 15'h0051, 3'd4, 1'b1);

    // LDI: three steps
    tick(); bus.opcode = 6'h05; #1; expect_cyc("ldi_t0", 15'h4800, 3'd0, 1'b0);
    tick(); #1; expect_cyc("ldi_t1", 15'h1500, 3'd1, 1'b0);
    tick(); #1; expect_cyc("ldi_t2", 15'h00C0, 3'd2, 1'b1);

    // JC not taken, then taken
    tick(); bus.opcode = 6'h07; #1; expect_cyc("jc0_t0", 15'h4800, 3'd0, 1'b0);
    tick(); tick(); #1; expect_cyc("jc0_t2", 15'h0000, 3'd2, 1'b1);
    tick(); bus.flag_c = 1'b1; #1; expect_cyc("jc1_t0", 15'h4800, 3'd0, 1'b0);
    tick(); tick(); #1; expect_cyc("jc1_t2", 15'h2080, 3'd2, 1'b1);

    // RAM stall in T1 for three cycles (NOP instruction)
    tick(); bus.opcode = 6'h00; bus.flag_c = 1'b0; #1;
    expect_cyc("stall_t0", 15'h4800, 3'd0, 1'b0);
    tick(); bus.mem_ready = 1'b0; #1; expect_cyc("stall_a", 15'h0400, 3'd1, 1'b0);
    tick(); #1; expect_cyc("stall_b", 15'h0400, 3'd1, 1'b0);
    tick(); #1; expect_cyc("stall_c", 15'h0400, 3'd1, 1'b0);
    tick(); bus.mem_ready = 1'b1; #1; expect_cyc("stall_go", 15'h1500, 3'd1, 1'b0);
    tick(); #1; expect_cyc("nop_t2", 15'h0000, 3'd2, 1'b1);

    // HLT, ten halted cycles, then resume
    tick(); bus.opcode = 6'h0F; #1; expect_cyc("hlt_t0", 15'h4800, 3'd0, 1'b0);
    tick(); tick(); #1; expect_cyc("hlt_t2", 15'h0000, 3'd2, 1'b1);
    chk("hlt_t2_halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      expect_cyc("halted", 15'h0000, 3'd0, 1'b0);
      chk("halted_flag", 32'(bus.halted), 32'd1);
    end
    bus.resume = 1'b1;
    tick(); bus.resume = 1'b0; #1;
    expect_cyc("resume", 15'h4800, 3'd0, 1'b0);
    chk("resume_halted", 32'(bus.halted), 32'd0);

    // Single-step LDA: one pulse every fourth cycle
    bus.opcode    = 6'h01;
    bus.step_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        tick(); bus.step = 1'b0; #1;
        expect_cyc("step_idle", sm_idle[k], sm_t[k], 1'b0);
      end
      tick(); bus.step = 1'b1; #1;
      expect_cyc("step_pulse", sm_full[k], sm_t[k], (k == 2) ? 1'b1 : 1'b0);
    end
    tick(); bus.step = 1'b0; bus.step_mode = 1'b0; #1;
    expect_cyc("step_exit_hold", 15'h0400, 3'd1, 1'b0);
    tick(); #1; expect_cyc("free_t1", 15'h1500, 3'd1, 1'b0);
    tick(); #1; expect_cyc("lda_t2", 15'h0880, 3'd2, 1'b0);
    tick(); #1; expect_cyc("lda_t3", 15'h0440, 3'd3, 1'b1);

    // Asynchronous reset mid-T3
    #2; rst = 1'b1; #1;
    expect_cyc("async_rst", 15'h0000, 3'd0, 1'b0);
    chk("async_rst_fetch", 32'(bus.fetch), 32'd1);
    chk("async_rst_halted", 32'(bus.halted), 32'd0);

    // Wide opcode with upper bits set decodes as NOP; resume while running is ignored
    tick(); rst = 1'b0; bus.opcode = 6'h12; bus.resume = 1'b1; #1;
    expect_cyc("wide_t0", 15'h4800, 3'd0, 1'b0);
    tick(); bus.resume = 1'b0; #1;
    expect_cyc("wide_t1", 15'h1500, 3'd1, 1'b0);
    chk("wide_t1_halted", 32'(bus.halted), 32'd0);
    tick(); #1; expect_cyc("wide_t2", 15'h0000, 3'd2, 1'b1);
    tick(); #1; expect_cyc("wide_next", 15'h4800, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
